// File: rtl/ql_bank_frame_loader.sv
// ql_bank_frame_loader
// Streams configuration words into a bit-line row register, then strobes the
// matching word line so each row of the tile's memory bank is written once per
// programming pass. Rows are walked 0..WL_W-1; each row sees a setup cycle,
// WL_PULSE cycles of word-line drive and a hold cycle with bl frozen.

module ql_bank_frame_loader #(
    parameter int BL_W     = 158,
    parameter int WL_W     = 158,
    parameter int DATA_W   = 16,
    parameter int WL_PULSE = 2
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [0:BL_W-1]   bl,
    output logic [0:WL_W-1]   wl,
    output logic              busy,
    output logic              done
);

    localparam int WPR   = (BL_W + DATA_W - 1) / DATA_W;
    localparam int ROW_W = (WL_W > 1) ? $clog2(WL_W) : 1;
    localparam int WC_W  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int PC_W  = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(WL_W - 1);
    localparam logic [WC_W-1:0]  LAST_WORD  = WC_W'(WPR - 1);
    localparam logic [PC_W-1:0]  LAST_PULSE = PC_W'(WL_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ROW_W-1:0]  row;
    logic [WC_W-1:0]   word_cnt;
    logic [PC_W-1:0]   pulse_cnt;
    logic              xfer;

    assign xfer = in_valid && in_ready;

    // State register; reset aborts any pass in flight.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencing and handshake outputs; in_ready depends on state alone.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (word_cnt == LAST_WORD)) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_next = S_PULSE;
            end
            S_PULSE: begin
                if (pulse_cnt == LAST_PULSE) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                state_next = (row == LAST_ROW) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Row, word and pulse counters; none of them wraps past its last value.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            row       <= '0;
            word_cnt  <= '0;
            pulse_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row      <= '0;
                        word_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (xfer && (word_cnt != LAST_WORD)) begin
                        word_cnt <= word_cnt + WC_W'(1);
                    end
                end
                S_SETTLE: begin
                    pulse_cnt <= '0;
                end
                S_PULSE: begin
                    if (pulse_cnt != LAST_PULSE) begin
                        pulse_cnt <= pulse_cnt + PC_W'(1);
                    end
                end
                S_HOLD: begin
                    if (row != LAST_ROW) begin
                        row      <= row + ROW_W'(1);
                        word_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Row assembly: word k lands on bl[k*DATA_W +: DATA_W]; bits past BL_W drop out.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            bl <= '0;
        end else if (xfer) begin
            for (int b = 0; b < BL_W; b++) begin
                if (word_cnt == WC_W'(b / DATA_W)) begin
                    bl[b] <= in_data[b % DATA_W];
                end
            end
        end
    end

    // Word-line decode: only the current row, and only while pulsing.
    always_comb begin
        wl = '0;
        for (int r = 0; r < WL_W; r++) begin
            if ((state == S_PULSE) && (row == ROW_W'(r))) begin
                wl[r] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ql_bank_frame_loader.sv
// tb_ql_bank_frame_loader
// Scoreboard bench: each pass pushes its expected word-line events and done
// timing into a queue; a monitor on the falling edge pops and compares them as
// the loader presents them, and also watches the wl/bl invariants every cycle.

module tb_ql_bank_frame_loader;

    localparam int BL_W        = 10;
    localparam int WL_W        = 3;
    localparam int DATA_W      = 4;
    localparam int WL_PULSE    = 2;
    localparam int PASS_CYCLES = 23;

    logic              prog_clk;
    logic              pReset;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [0:BL_W-1]   bl;
    logic [0:WL_W-1]   wl;
    logic              busy;
    logic              done;

    ql_bank_frame_loader #(
        .BL_W     (BL_W),
        .WL_W     (WL_W),
        .DATA_W   (DATA_W),
        .WL_PULSE (WL_PULSE)
    ) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .bl       (bl),
        .wl       (wl),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        bit              is_done;
        logic [0:BL_W-1] bl;
        logic [0:WL_W-1] wl;
        int              edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;

    logic [0:WL_W-1]   wl_row  [3] = '{3'b100, 3'b010, 3'b001};

    logic [DATA_W-1:0] words_a [9] = '{4'h5, 4'hA, 4'h3, 4'hF, 4'h0, 4'h1, 4'h9, 4'h6, 4'hC};
    logic [0:BL_W-1]   rows_a  [3] = '{10'b1010010111, 10'b1111000010, 10'b1001011000};

    logic [DATA_W-1:0] words_b [9] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hC, 4'h3, 4'h0, 4'hF};
    logic [0:BL_W-1]   rows_b  [3] = '{10'b0000000011, 10'b1111111100, 10'b1100000011};

    // Free-running clock.
    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Edge counter used to time-stamp expected done pulses.
    always @(posedge prog_clk) begin
        edge_cnt <= edge_cnt + 1;
    end

    function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Monitor: pops expectations on each word-line rise and done pulse, checks invariants.
    logic [0:WL_W-1] prev_wl = '0;
    logic [0:BL_W-1] prev_bl = '0;
    int              pulse_len = 0;
    bit              aborted = 1'b0;
    bit              busy_chk = 1'b0;

    always @(negedge prog_clk) begin
        exp_t e;
        if (busy_chk) begin
            check_output("busy_after_done", {31'b0, busy}, 32'd0);
            busy_chk = 1'b0;
        end
        check_output("wl_onehot0", {31'b0, $onehot0(wl)}, 32'd1);
        if ((wl != '0) && (prev_wl != '0)) begin
            check_output("bl_stable_under_wl", {22'b0, bl}, {22'b0, prev_bl});
        end
        if ((wl != '0) && (prev_wl == '0)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pulse actual wl=%b required none", wl);
            end else begin
                e = exp_q.pop_front();
                check_output("event_is_pulse", {31'b0, e.is_done}, 32'd0);
                check_output("row_bl", {22'b0, bl}, {22'b0, e.bl});
                check_output("row_wl", {29'b0, wl}, {29'b0, e.wl});
            end
            pulse_len = 0;
            aborted   = 1'b0;
        end
        if (wl != '0) begin
            pulse_len++;
            if (pReset) begin
                aborted = 1'b1;
            end
        end
        if ((wl == '0) && (prev_wl != '0) && !aborted) begin
            check_output("pulse_len", pulse_len, WL_PULSE);
        end
        if (done) begin
            check_output("busy_in_done", {31'b0, busy}, 32'd1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done actual done=1 required done=0");
            end else begin
                e = exp_q.pop_front();
                check_output("event_is_done", {31'b0, e.is_done}, 32'd1);
                check_output("done_cycle", edge_cnt, e.edge_n);
            end
            busy_chk = 1'b1;
        end
        prev_wl = wl;
        prev_bl = bl;
    end

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int g;
        g = 0;
        while (!in_ready && (g < 50)) begin
            step();
            g++;
        end
        ok = in_ready;
    endtask

    // One word over the handshake; with stall, one LOAD cycle is spent with in_valid low first.
    task automatic send_word(input logic [DATA_W-1:0] w, input bit stall);
        bit ok;
        if (stall) begin
            in_valid = 1'b0;
            in_data  = 4'h0;
            wait_ready(ok);
            check_output("ready_wait", {31'b0, ok}, 32'd1);
            step();
        end
        in_valid = 1'b1;
        in_data  = w;
        wait_ready(ok);
        check_output("ready_wait", {31'b0, ok}, 32'd1);
        step();
    endtask

    // Full programming pass with expectations queued up front.
    task automatic apply_stimulus(input logic [DATA_W-1:0] words [9], input logic [0:BL_W-1] rows [3],
                                  input logic [8:0] stall_mask, input bit hold_start);
        exp_t e;
        int   stalls;
        int   sample_edge;
        int   g;
        stalls      = $countones(stall_mask);
        start       = 1'b1;
        sample_edge = edge_cnt + 1;
        for (int r = 0; r < 3; r++) begin
            e.is_done = 1'b0;
            e.bl      = rows[r];
            e.wl      = wl_row[r];
            e.edge_n  = 0;
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.bl      = '0;
        e.wl      = '0;
        e.edge_n  = sample_edge + PASS_CYCLES - 2 + stalls;
        exp_q.push_back(e);
        step();
        if (!hold_start) begin
            start = 1'b0;
        end
        for (int k = 0; k < 9; k++) begin
            send_word(words[k], stall_mask[k]);
        end
        if (hold_start) begin
            while (edge_cnt < sample_edge + PASS_CYCLES - 1 + stalls) begin
                step();
            end
            start = 1'b0;
        end
        g = 0;
        while ((exp_q.size() != 0) && (g < 100)) begin
            step();
            g++;
        end
        check_output("queue_drained", exp_q.size(), 32'd0);
        step();
        step();
    endtask

    // Reset lands in the first PULSE cycle of row 1.
    task automatic reset_mid_pass();
        exp_t e;
        start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            e.is_done = 1'b0;
            e.bl      = rows_a[r];
            e.wl      = wl_row[r];
            e.edge_n  = 0;
            exp_q.push_back(e);
        end
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send_word(words_a[k], 1'b0);
        end
        step();
        pReset = 1'b1;
        step();
        pReset = 1'b0;
        check_output("abort_wl", {29'b0, wl}, 32'd0);
        check_output("abort_bl", {22'b0, bl}, 32'd0);
        check_output("abort_busy", {31'b0, busy}, 32'd0);
        check_output("abort_in_ready", {31'b0, in_ready}, 32'd0);
        check_output("abort_queue", exp_q.size(), 32'd0);
        step();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        pReset   = 1'b1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hF;
        step();
        step();
        pReset = 1'b0;

        $display("[TB] idle with in_valid high");
        for (int i = 0; i < 5; i++) begin
            check_output("idle_in_ready", {31'b0, in_ready}, 32'd0);
            check_output("idle_bl", {22'b0, bl}, 32'd0);
            check_output("idle_wl", {29'b0, wl}, 32'd0);
            check_output("idle_busy", {31'b0, busy}, 32'd0);
            check_output("idle_done", {31'b0, done}, 32'd0);
            step();
        end

        $display("[TB] pass with always-valid source");
        apply_stimulus(words_a, rows_a, 9'h000, 1'b0);

        $display("[TB] pass with in_valid toggling");
        apply_stimulus(words_a, rows_a, 9'h0AA, 1'b0);

        $display("[TB] pass with excess bits in last word");
        apply_stimulus(words_b, rows_b, 9'h000, 1'b0);

        $display("[TB] reset during row 1 pulse");
        reset_mid_pass();
        apply_stimulus(words_a, rows_a, 9'h000, 1'b0);

        $display("[TB] start held through pass and done");
        apply_stimulus(words_b, rows_b, 9'h000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_output("no_restart_busy", {31'b0, busy}, 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
